// File: rtl/rf_pkg.sv
// Shared constants and helpers for the register file slice.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package rf_pkg;

   localparam int RF_DATA_SIZE = 8;
   localparam int RF_ADDR_SIZE = 3;
   localparam int RF_DEPTH     = 2**RF_ADDR_SIZE;

   // Number of entries for a given address width.
   function automatic int rf_depth(input int addr_size);
      return 2**addr_size;
   endfunction

endpackage

// File: rtl/register_file_if.sv
// Bus between IR decode / ALU operand logic and the register file.
// Latency: n/a (wiring only); read data is registered inside the register file.
// Backpressure: none; every write and enabled read is accepted on its edge.
// Ports: load/wr_addr/wr_data (write), rd_en_x/rd_addr_x/rd_data_x (reads A and B).
interface register_file_if
   import rf_pkg::*;
#(
   parameter int data_size = RF_DATA_SIZE,
   parameter int addr_size = RF_ADDR_SIZE
);

   logic                 load;
   logic [addr_size-1:0] wr_addr;
   logic [data_size-1:0] wr_data;
   logic                 rd_en_a;
   logic [addr_size-1:0] rd_addr_a;
   logic [data_size-1:0] rd_data_a;
   logic                 rd_en_b;
   logic [addr_size-1:0] rd_addr_b;
   logic [data_size-1:0] rd_data_b;

   modport master (
      output load, wr_addr, wr_data,
      output rd_en_a, rd_addr_a,
      output rd_en_b, rd_addr_b,
      input  rd_data_a, rd_data_b
   );

   modport slave (
      input  load, wr_addr, wr_data,
      input  rd_en_a, rd_addr_a,
      input  rd_en_b, rd_addr_b,
      output rd_data_a, rd_data_b
   );

endinterface

// File: rtl/rf_cell.sv
// Single loadable register entry of the register file.
// Latency: q updates on the rising edge where load=1; async clear when reset is low.
// Backpressure: none.
// Ports: clock, reset (async active-low), load, d (next value), q (stored value).
module rf_cell
   import rf_pkg::*;
#(
   parameter int data_size = RF_DATA_SIZE
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 load,
   input  logic [data_size-1:0] d,
   output logic [data_size-1:0] q
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/register_file.sv
// 2**addr_size x data_size register file, one write port, two registered read ports.
// Latency: 1 cycle read, same-cycle write visible to reads through the bypass.
// Backpressure: none; reads hold their output while their enable is low.
// Ports: clock, reset (async active-low), bus (register_file_if slave).
module register_file
   import rf_pkg::*;
#(
   parameter int data_size = RF_DATA_SIZE,
   parameter int addr_size = RF_ADDR_SIZE,
   parameter bit zero_reg  = 1'b1
) (
   input  logic           clock,
   input  logic           reset,
   register_file_if.slave bus
);

   localparam int depth = rf_depth(addr_size);

   logic [depth-1:0][data_size-1:0] entry;
   logic [data_size-1:0]            val_a;
   logic [data_size-1:0]            val_b;
   logic [data_size-1:0]            rd_a_q;
   logic [data_size-1:0]            rd_b_q;

   // Storage: entry 0 becomes a constant when it is the hard-wired zero.
   for (genvar i = 0; i < depth; i++) begin : g_entry
      if (zero_reg && (i == 0)) begin : g_zero
         assign entry[i] = '0;
      end else begin : g_cell
         rf_cell #(.data_size(data_size)) u_cell (
            .clock (clock),
            .reset (reset),
            .load  (bus.load && (bus.wr_addr == addr_size'(i))),
            .d     (bus.wr_data),
            .q     (entry[i])
         );
      end
   end

   // Zero entry wins over the bypass, so a write to entry 0 can never leak out.
   function automatic logic [data_size-1:0] read_value(
      input logic [addr_size-1:0]            addr,
      input logic                            load,
      input logic [addr_size-1:0]            wr_addr,
      input logic [data_size-1:0]            wr_data,
      input logic [depth-1:0][data_size-1:0] ent
   );
      if (zero_reg && (addr == '0)) begin
         return '0;
      end else if (load && (wr_addr == addr)) begin
         return wr_data;
      end else begin
         return ent[addr];
      end
   endfunction

   always_comb begin
      val_a = read_value(bus.rd_addr_a, bus.load, bus.wr_addr, bus.wr_data, entry);
      val_b = read_value(bus.rd_addr_b, bus.load, bus.wr_addr, bus.wr_data, entry);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_a_q <= '0;
         rd_b_q <= '0;
      end else begin
         if (bus.rd_en_a) begin
            rd_a_q <= val_a;
         end
         if (bus.rd_en_b) begin
            rd_b_q <= val_b;
         end
      end
   end

   assign bus.rd_data_a = rd_a_q;
   assign bus.rd_data_b = rd_b_q;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: default, zero_reg=0 and 5x16 instances.
// Latency: n/a.
// Backpressure: n/a.
module tb_register_file;
   import rf_pkg::*;

   logic clock;
   logic reset;
   int   errors;
   int   checks;

   register_file_if #(.data_size(8), .addr_size(3)) bus0 ();
   register_file_if #(.data_size(8), .addr_size(3)) bus1 ();
   register_file_if #(.data_size(5), .addr_size(4)) bus2 ();

   register_file #(.data_size(8), .addr_size(3), .zero_reg(1'b1)) dut0 (
      .clock (clock), .reset (reset), .bus (bus0.slave)
   );
   register_file #(.data_size(8), .addr_size(3), .zero_reg(1'b0)) dut1 (
      .clock (clock), .reset (reset), .bus (bus1.slave)
   );
   register_file #(.data_size(5), .addr_size(4), .zero_reg(1'b1)) dut2 (
      .clock (clock), .reset (reset), .bus (bus2.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b0;
      bus0.load = 1'b0; bus0.wr_addr = '0; bus0.wr_data = '0;
      bus0.rd_en_a = 1'b0; bus0.rd_addr_a = '0; bus0.rd_en_b = 1'b0; bus0.rd_addr_b = '0;
      bus1.load = 1'b0; bus1.wr_addr = '0; bus1.wr_data = '0;
      bus1.rd_en_a = 1'b0; bus1.rd_addr_a = '0; bus1.rd_en_b = 1'b0; bus1.rd_addr_b = '0;
      bus2.load = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0;
      bus2.rd_en_a = 1'b0; bus2.rd_addr_a = '0; bus2.rd_en_b = 1'b0; bus2.rd_addr_b = '0;
      #2;

      // Reset: writes and reads attempted during reset must have no effect.
      check("reset_init_a", 32'(bus0.rd_data_a), 32'h0);
      check("reset_init_b", 32'(bus0.rd_data_b), 32'h0);
      bus0.load = 1'b1; bus0.wr_addr = 3'd3; bus0.wr_data = 8'hFF;
      bus0.rd_en_a = 1'b1; bus0.rd_addr_a = 3'd3;
      bus0.rd_en_b = 1'b1; bus0.rd_addr_b = 3'd3;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("reset_hold_a", 32'(bus0.rd_data_a), 32'h0);
         check("reset_hold_b", 32'(bus0.rd_data_b), 32'h0);
      end
      reset = 1'b1;
      bus0.load = 1'b0;
      for (int k = 0; k < RF_DEPTH; k++) begin
         bus0.rd_addr_a = 3'(k);
         bus0.rd_addr_b = 3'(k);
         tick();
         check("post_reset_a", 32'(bus0.rd_data_a), 32'h0);
         check("post_reset_b", 32'(bus0.rd_data_b), 32'h0);
      end

      // Write then read.
      bus0.rd_en_a = 1'b0; bus0.rd_en_b = 1'b0;
      bus0.load = 1'b1; bus0.wr_addr = 3'd3; bus0.wr_data = 8'hA5;
      tick();
      bus0.load = 1'b0;
      bus0.rd_en_a = 1'b1; bus0.rd_addr_a = 3'd3;
      bus0.rd_en_b = 1'b1; bus0.rd_addr_b = 3'd4;
      tick();
      check("wr_rd_a3", 32'(bus0.rd_data_a), 32'hA5);
      check("wr_rd_b4", 32'(bus0.rd_data_b), 32'h00);

      // Bypass: same-cycle write and read of entry 5 returns the new data.
      bus0.rd_en_a = 1'b0; bus0.rd_en_b = 1'b0;
      bus0.load = 1'b1; bus0.wr_addr = 3'd5; bus0.wr_data = 8'h11;
      tick();
      bus0.wr_data = 8'h22;
      bus0.rd_en_a = 1'b1; bus0.rd_addr_a = 3'd5;
      bus0.rd_en_b = 1'b1; bus0.rd_addr_b = 3'd5;
      tick();
      check("bypass_a", 32'(bus0.rd_data_a), 32'h22);
      check("bypass_b", 32'(bus0.rd_data_b), 32'h22);
      bus0.load = 1'b0;
      tick();
      check("stored_after_bypass", 32'(bus0.rd_data_a), 32'h22);

      // Zero register on dut0, ordinary entry 0 on dut1; the write also bypasses to port A.
      bus0.load = 1'b1; bus0.wr_addr = 3'd0; bus0.wr_data = 8'h7E;
      bus0.rd_addr_a = 3'd0;
      bus1.load = 1'b1; bus1.wr_addr = 3'd0; bus1.wr_data = 8'h7E;
      bus1.rd_en_a = 1'b1; bus1.rd_addr_a = 3'd0;
      tick();
      check("zero_bypass_z1", 32'(bus0.rd_data_a), 32'h00);
      check("zero_bypass_z0", 32'(bus1.rd_data_a), 32'h7E);
      bus0.load = 1'b0;
      bus1.load = 1'b0;
      tick();
      check("zero_read_z1", 32'(bus0.rd_data_a), 32'h00);
      check("zero_read_z0", 32'(bus1.rd_data_a), 32'h7E);

      // Enable hold: port A keeps A5 while entry 3 is overwritten with 00.
      bus0.rd_addr_a = 3'd3;
      bus0.rd_en_b = 1'b0;
      tick();
      check("hold_first_read", 32'(bus0.rd_data_a), 32'hA5);
      bus0.rd_en_a = 1'b0;
      bus0.load = 1'b1; bus0.wr_addr = 3'd3; bus0.wr_data = 8'h00;
      tick();
      check("hold_a", 32'(bus0.rd_data_a), 32'hA5);
      bus0.load = 1'b0;
      bus0.rd_en_b = 1'b1; bus0.rd_addr_b = 3'd3;
      tick();
      check("hold_a_again", 32'(bus0.rd_data_a), 32'hA5);
      check("overwrite_b3", 32'(bus0.rd_data_b), 32'h00);

      // Write 5A to entry 6 and read it back, then reset asynchronously mid-cycle.
      bus0.load = 1'b1; bus0.wr_addr = 3'd6; bus0.wr_data = 8'h5A;
      bus0.rd_addr_b = 3'd6;
      tick();
      check("pre_areset_b", 32'(bus0.rd_data_b), 32'h5A);
      bus0.load = 1'b0;
      #3;
      reset = 1'b0;
      #1;
      check("areset_a", 32'(bus0.rd_data_a), 32'h00);
      check("areset_b", 32'(bus0.rd_data_b), 32'h00);
      #2;
      reset = 1'b1;
      bus0.rd_en_a = 1'b1; bus0.rd_addr_a = 3'd5;
      tick();
      check("areset_entry5", 32'(bus0.rd_data_a), 32'h00);
      check("areset_entry6", 32'(bus0.rd_data_b), 32'h00);

      // Parameter sweep: 5-bit data, 16 entries, entry 0 hard-wired to zero.
      bus2.load = 1'b1;
      for (int k = 0; k < 16; k++) begin
         bus2.wr_addr = 4'(k);
         bus2.wr_data = 5'(k + 1);
         tick();
      end
      bus2.load = 1'b0;
      bus2.rd_en_a = 1'b1; bus2.rd_en_b = 1'b1;
      for (int k = 0; k < 16; k++) begin
         int ea;
         int eb;
         bus2.rd_addr_a = 4'(k);
         bus2.rd_addr_b = 4'(15 - k);
         ea = (k == 0) ? 0 : (k + 1) % 32;
         eb = ((15 - k) == 0) ? 0 : (16 - k) % 32;
         tick();
         check("sweep_a", 32'(bus2.rd_data_a), 32'(ea));
         check("sweep_b", 32'(bus2.rd_data_b), 32'(eb));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/register_file.md
# register_file

Parametrised multi-entry register file for the lab datapath. It generalises the single loadable register into 2**addr_size entries of data_size bits, with one write port and two independently enabled synchronous read ports. Read-after-write bypass and an optional hard-wired zero entry are included. It sits between the IR decode fields (register addresses) and the ALU operand inputs.

## Interface
Parameters:
- data_size, 8: width of each entry and of the data ports.
- addr_size, 3: address width; depth is 2**addr_size entries.
- zero_reg, 1: 1 makes entry 0 read as 0 and ignore writes; 0 makes entry 0 an ordinary register.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low. Low clears all entries and both read outputs immediately.
- load  in  1  write enable.
- wr_addr  in  addr_size  write address.
- wr_data  in  data_size  write data.
- rd_en_a  in  1  read enable, port A.
- rd_addr_a  in  addr_size  read address, port A.
- rd_data_a  out  data_size  registered read data, port A.
- rd_en_b  in  1  read enable, port B.
- rd_addr_b  in  addr_size  read address, port B.
- rd_data_b  out  data_size  registered read data, port B.

## Operation
- Reset (reset=0, asynchronous): every entry is 0, rd_data_a = 0, rd_data_b = 0. This holds for as long as reset is low. Clock edges during reset have no effect.
- Write: on a rising edge with load=1, entry[wr_addr] <= wr_data.
  - Exception: zero_reg=1 and wr_addr=0. The write is dropped; there is no error indication.
- Read, port A: on a rising edge with rd_en_a=1, rd_data_a <= value(rd_addr_a).
  - With rd_en_a=0, rd_data_a holds its previous value.
  - Port B behaves identically and independently.
- value(addr), in priority order:
  1. 0 if zero_reg=1 and addr=0.
  2. wr_data if load=1 and wr_addr=addr. This is the bypass: a read in the same cycle as a write returns the new data.
  3. Otherwise the stored entry[addr].
- Both ports may read the same address in the same cycle; both return the same value.
- There are no illegal addresses, since every address in 2**addr_size is valid.
- Widths are exact. There is no arithmetic, truncation or extension inside the block.

## Timing
- Read latency is 1 cycle. The address and enable are presented before edge N; the data is valid after edge N and stable until the next enabled edge.
- Write latency: the entry updates at edge N. A read issued in the same cycle sees the new data through the bypass. A read issued in a later cycle sees the stored data.
- Simultaneous write and read of the same address: the read returns wr_data, not the old contents.
- Reset asserted mid-operation: outputs drop to 0 asynchronously, without waiting for a clock edge. Any in-flight write in that cycle is lost.
- Reset deassertion: the first rising edge with reset=1 is a normal operating edge.
- There is no combinational path from inputs to outputs. Outputs change only at a clock edge or on reset assertion.

## Structure
- Shared package rf_pkg holds:
  - the default constants RF_DATA_SIZE=8, RF_ADDR_SIZE=3;
  - a localparam expression for depth, 2**addr_size.
- One sub-module, rf_cell: a single data_size register with load and async active-low clear.
  - It is instantiated 2**addr_size times through a generate loop.
  - When zero_reg=1, entry 0 is tied to constant 0 instead of instantiating rf_cell.
- The read mux, bypass compare and output registers live in register_file itself.

## Test plan
Default parameters (data_size=8, addr_size=3, zero_reg=1) unless stated otherwise.
- **Reset:** hold reset=0, load=1, wr_data=8'hFF for 3 edges, then release and read all 8 addresses. Required: rd_data_a = rd_data_b = 0 during reset, and every entry reads 0 afterwards.
- **Write then read:** write 8'hA5 to address 3 at edge 1. Set rd_addr_a=3 with rd_en_a=1 at edge 2. Required: rd_data_a = 8'hA5 after edge 2. Port B reading address 4 returns 0.
- **Bypass:** entry 5 holds 8'h11. In one cycle, write 8'h22 to address 5 while both ports read address 5. Required: rd_data_a = rd_data_b = 8'h22 after that edge.
- **Zero register:** write 8'h7E to address 0, then read it. Required: 8'h00.
  - Repeat with zero_reg=0. Required: 8'h7E.
- **Enable hold and async reset:** read address 3 (8'hA5) on port A, then drop rd_en_a and write 8'h00 to address 3. Required: rd_data_a stays 8'hA5.
  - Then pulse reset low between clock edges. Required: rd_data_a goes to 0 before the next edge.
- **Parameter sweep:** data_size=5, addr_size=4. Write address i = i+1 for all 16 entries, then read all 16 back on both ports in alternating order. Required: every read returns i+1 (mod 32), and entry 0 returns 0.
